// File: rtl/fetch_queue_if.sv
// Instruction-bus read channels between the fetch front end (master) and memory (slave).
interface fetch_queue_if #(
  parameter int bus_width = 32
) ();
  logic                 i_raddr_valid;
  logic                 i_raddr_ready;
  logic [bus_width-1:0] i_raddr;
  logic                 i_rdata_valid;
  logic                 i_rdata_ready;
  logic [bus_width-1:0] i_rdata;

  modport master (
    output i_raddr_valid, i_raddr, i_rdata_ready,
    input  i_raddr_ready, i_rdata_valid, i_rdata
  );

  modport slave (
    input  i_raddr_valid, i_raddr, i_rdata_ready,
    output i_raddr_ready, i_rdata_valid, i_rdata
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order instruction queue,
// branch redirect with flush and stale-response discard.
module fetch_queue #(
  parameter int                bus_width       = 32,
  parameter int                pc_width        = 32,
  parameter logic [pc_width-1:0] pc_init       = '0,
  parameter int                inst_width      = 32,
  parameter int                depth           = 4,
  parameter int                max_outstanding = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_queue_if.master         ibus,
  input  logic                  redirect,
  input  logic [pc_width-1:0]   redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [inst_width-1:0] inst,
  output logic [pc_width-1:0]   inst_pc
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam int SW = CW + 1;
  localparam int TW = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(max_outstanding - 1)) return '0;
    else return p + TW'(1);
  endfunction

  logic                req_valid_q, req_valid_d;
  logic                req_stale_q, req_stale_d;
  logic [pc_width-1:0] req_addr_q, req_addr_d;
  logic [pc_width-1:0] pc_q, pc_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       out_q, out_d;
  logic [CW-1:0]       stale_q, stale_d;
  logic [TW-1:0]       tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [inst_width-1:0] inst_mem_q [depth];
  logic [pc_width-1:0]   pc_mem_q   [depth];
  logic [pc_width-1:0]   tag_mem_q  [max_outstanding];

  logic                accept, resp, drop, push, pop, can_issue;
  logic [pc_width-1:0] target;

  always_comb begin
    accept = req_valid_q & ibus.i_raddr_ready;
    resp   = ibus.i_rdata_valid & (out_q != '0);
    drop   = resp & (stale_q != '0);
    push   = resp & ~drop & ~redirect;
    pop    = (count_q != '0) & inst_ready & ~redirect;

    out_d    = out_q + CW'(accept) - CW'(resp);
    tag_wr_d = accept ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = resp ? tag_inc(tag_rd_q) : tag_rd_q;

    // On redirect every request still in flight after this cycle belongs to the old path.
    if (redirect) stale_d = out_d;
    else          stale_d = stale_q - CW'(drop) + CW'(accept & req_stale_q);

    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    target    = redirect ? {redirect_pc[pc_width-1:2], 2'b00} : pc_q;
    can_issue = ((SW'(count_d) + SW'(out_d)) < SW'(depth)) &&
                (out_d < CW'(max_outstanding));

    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_stale_d = req_stale_q;
    pc_d        = target;
    // A raised request is never withdrawn; a redirect only marks it stale.
    if (!req_valid_q || accept) begin
      req_valid_d = can_issue;
      req_stale_d = 1'b0;
      if (can_issue) begin
        req_addr_d = target;
        pc_d       = target + pc_width'(4);
      end
    end else begin
      req_stale_d = req_stale_q | redirect;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_q <= 1'b0;
      req_stale_q <= 1'b0;
      req_addr_q  <= pc_init;
      pc_q        <= pc_init;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      stale_q     <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_stale_q <= req_stale_d;
      req_addr_q  <= req_addr_d;
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      stale_q     <= stale_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
    end
  end

  // Storage arrays carry data only; validity is tracked by the reset pointers above.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= ibus.i_rdata[inst_width-1:0];
      pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
    end
    if (accept) tag_mem_q[tag_wr_q] <= req_addr_q;
  end

  assign ibus.i_raddr_valid = req_valid_q;
  assign ibus.i_raddr       = bus_width'(req_addr_q);
  assign ibus.i_rdata_ready = 1'b1;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-cycle in-order memory returning addr ^ 0xA5A5_0000.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        mem_hold;
  logic        mem_flush;
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] mq [$];

  fetch_queue_if #(.bus_width(32)) bus ();

  fetch_queue #(
    .bus_width(32), .pc_width(32), .pc_init(32'h0), .inst_width(32),
    .depth(4), .max_outstanding(2)
  ) dut (
    .clk(clk), .rst(rst), .ibus(bus),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // In-order memory: answers the oldest accepted address the cycle after acceptance.
  always @(posedge clk) begin
    if (mem_flush) begin
      mq.delete();
      bus.i_rdata_valid <= 1'b0;
      bus.i_rdata       <= '0;
    end else begin
      if (bus.i_rdata_valid && mq.size() > 0) void'(mq.pop_front());
      if (bus.i_raddr_valid && bus.i_raddr_ready) mq.push_back(bus.i_raddr);
      if (!mem_hold && mq.size() > 0) begin
        bus.i_rdata_valid <= 1'b1;
        bus.i_rdata       <= mq[0] ^ 32'hA5A5_0000;
      end else begin
        bus.i_rdata_valid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_flush = 1'b1;
    redirect = 1'b0;
    step();
    step();
    rst = 1'b1;
    mem_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;
    mem_hold = 1'b0;
    mem_flush = 1'b1;
    bus.i_raddr_ready = 1'b1;
    step();
    step();
    check("rst_raddr_valid", 32'(bus.i_raddr_valid), 32'h0);
    check("rst_raddr",       bus.i_raddr,            32'h0);
    check("rst_inst_valid",  32'(inst_valid),        32'h0);
    check("rst_inst",        inst,                   32'h0);
    check("rst_inst_pc",     inst_pc,                32'h0);
    check("rst_rdata_ready", 32'(bus.i_rdata_ready), 32'h1);

    // Streaming: one request and one instruction per cycle.
    rst = 1'b1;
    mem_flush = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("stream_raddr_valid", 32'(bus.i_raddr_valid), 32'h1);
      check("stream_raddr", bus.i_raddr, 32'(4 * (k - 1)));
      if (k >= 3) begin
        check("stream_inst_valid", 32'(inst_valid), 32'h1);
        check("stream_inst_pc", inst_pc, 32'(4 * (k - 3)));
        check("stream_inst", inst, 32'(4 * (k - 3)) ^ 32'hA5A5_0000);
      end
    end

    // Decoder stalled: queue fills with 0,4,8,C, issue stops, resumes after one pop.
    inst_ready = 1'b0;
    do_reset();
    for (int k = 1; k <= 4; k++) step();
    check("full_raddr_valid_e4", 32'(bus.i_raddr_valid), 32'h1);
    check("full_raddr_e4", bus.i_raddr, 32'hC);
    step();
    check("full_raddr_valid_e5", 32'(bus.i_raddr_valid), 32'h0);
    for (int k = 6; k <= 8; k++) begin
      step();
      check("full_raddr_valid_hold", 32'(bus.i_raddr_valid), 32'h0);
      check("full_inst_valid", 32'(inst_valid), 32'h1);
      check("full_inst_pc", inst_pc, 32'h0);
    end
    inst_ready = 1'b1;
    step();
    check("resume_raddr_valid", 32'(bus.i_raddr_valid), 32'h1);
    check("resume_raddr", bus.i_raddr, 32'h10);
    check("resume_inst_pc", inst_pc, 32'h4);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("drain_inst_valid", 32'(inst_valid), 32'h1);
      check("drain_inst_pc", inst_pc, 32'(4 * (k + 1)));
      check("drain_inst", inst, 32'(4 * (k + 1)) ^ 32'hA5A5_0000);
    end

    // Bus backpressure: address 0x8 held for three cycles, no PC skipped.
    do_reset();
    for (int k = 1; k <= 3; k++) step();
    check("bp_raddr_e3", bus.i_raddr, 32'h8);
    bus.i_raddr_ready = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      step();
      check("bp_raddr_valid", 32'(bus.i_raddr_valid), 32'h1);
      check("bp_raddr_hold", bus.i_raddr, 32'h8);
    end
    check("bp_inst_valid_gap", 32'(inst_valid), 32'h0);
    bus.i_raddr_ready = 1'b1;
    step();
    check("bp_raddr_next", bus.i_raddr, 32'hC);
    step();
    check("bp_inst_valid_8", 32'(inst_valid), 32'h1);
    check("bp_inst_pc_8", inst_pc, 32'h8);
    step();
    check("bp_inst_pc_c", inst_pc, 32'hC);

    // Redirect to 0x103 with two requests outstanding.
    mem_hold = 1'b1;
    do_reset();
    for (int k = 1; k <= 3; k++) step();
    check("rd_credit_stop", 32'(bus.i_raddr_valid), 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    mem_hold = 1'b0;
    check("rd_inst_valid_e4", 32'(inst_valid), 32'h0);
    check("rd_raddr_valid_e4", 32'(bus.i_raddr_valid), 32'h0);
    step();
    step();
    check("rd_drop1_inst_valid", 32'(inst_valid), 32'h0);
    check("rd_new_raddr_valid", 32'(bus.i_raddr_valid), 32'h1);
    check("rd_new_raddr", bus.i_raddr, 32'h100);
    step();
    check("rd_drop2_inst_valid", 32'(inst_valid), 32'h0);
    step();
    check("rd_inst_valid", 32'(inst_valid), 32'h1);
    check("rd_inst_pc", inst_pc, 32'h100);
    check("rd_inst", inst, 32'hA5A5_0100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    for (int k = 1; k <= 3; k++) step();
    check("rp_pre_inst_valid", 32'(inst_valid), 32'h1);
    check("rp_pre_rdata_valid", 32'(bus.i_rdata_valid), 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("rp_flush_inst_valid", 32'(inst_valid), 32'h0);
    check("rp_raddr", bus.i_raddr, 32'h200);
    step();
    check("rp_stale_inst_valid", 32'(inst_valid), 32'h0);
    step();
    check("rp_inst_pc", inst_pc, 32'h200);
    check("rp_inst", inst, 32'hA5A5_0200);

    // Reset pulse with two outstanding; late responses must be ignored.
    mem_hold = 1'b1;
    do_reset();
    for (int k = 1; k <= 3; k++) step();
    rst = 1'b0;
    bus.i_raddr_ready = 1'b0;
    #1;
    check("mid_rst_raddr_valid", 32'(bus.i_raddr_valid), 32'h0);
    check("mid_rst_raddr", bus.i_raddr, 32'h0);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_inst_pc", inst_pc, 32'h0);
    step();
    rst = 1'b1;
    mem_hold = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("late_rsp_inst_valid", 32'(inst_valid), 32'h0);
    end
    check("restart_raddr_valid", 32'(bus.i_raddr_valid), 32'h1);
    check("restart_raddr", bus.i_raddr, 32'h0);
    bus.i_raddr_ready = 1'b1;
    step();
    check("restart_wait_inst_valid", 32'(inst_valid), 32'h0);
    step();
    check("restart_inst_valid", 32'(inst_valid), 32'h1);
    check("restart_inst_pc", inst_pc, 32'h0);
    check("restart_inst", inst, 32'hA5A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
